hw_qsys_cpu_2_cpu_div_cell: RTL and testbench
=============================================

HW_QSYS_CPU_2_CPU_DIV_CELL -- requirements
Module: hw_qsys_cpu_2_cpu_div_cell

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; only 32 is supported.
REQ-002 Port: clk  in  1  sole clock, all state on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: E_src1  in  32  dividend.
REQ-005 Port: E_src2  in  32  divisor.
REQ-006 Port: E_div_signed  in  1  1 = signed op, 0 = unsigned op.
REQ-007 Port: div_in_valid / div_in_ready  in / out  1 / 1  operand handshake.
REQ-008 Port: div_kill  in  1  abort the in-flight op (pipeline flush).
REQ-009 Port: M_div_quot / M_div_rem  out  32 / 32  quotient and remainder.
REQ-010 Port: M_div_by_zero  out  1  divisor was zero.
REQ-011 Port: div_out_valid / div_out_ready  out / in  1 / 1  result handshake.

Function
REQ-012 FSM SHALL have four states: IDLE -> RUN -> FIX -> DONE -> IDLE.
REQ-013 div_in_ready SHALL be 1 only in IDLE; accept = div_in_valid & div_in_ready & ~div_kill.
REQ-014 On accept, the block SHALL latch operands, the sign flags and |operand| (signed op), then enter RUN.
REQ-015 RUN SHALL do 32 radix-2 restoring iterations, one per cycle, with a 6-bit counter counting 31..0; it SHALL enter FIX when the counter reaches 0.
REQ-016 FIX SHALL apply signs: quotient negated if operand signs differ; remainder takes the dividend's sign. FIX is a pass-through for unsigned ops.
REQ-017 div_out_valid SHALL assert exactly 34 cycles after the accept edge and hold with stable outputs until div_out_ready=1; the block SHALL then return to IDLE on the next edge.
REQ-018 Divisor 0 SHALL yield quot=0xFFFFFFFF, rem=original E_src1 and M_div_by_zero=1, with the same 34-cycle latency, for signed and unsigned ops.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quot=0x80000000, rem=0 and raise no flag.
REQ-020 div_kill in RUN, FIX or DONE SHALL force IDLE on the next edge with div_out_valid=0; div_kill in IDLE SHALL block acceptance.
REQ-021 Outputs SHALL be registered, with no combinational path from inputs to div_out_valid or result ports.
REQ-022 M_div_by_zero SHALL be 0 whenever div_out_valid=0.

Reset
REQ-023 On reset the block SHALL enter IDLE with div_in_ready=1, div_out_valid=0, M_div_quot=0, M_div_rem=0, M_div_by_zero=0 and counter=0.
REQ-024 Reset mid-operation SHALL discard the op, produce no result, and have priority over div_kill and accept.

Configuration
REQ-025 Macro HW_QSYS_CPU_2_CPU_DIV_SIGNED_EN: when defined, E_div_signed is honoured per REQ-016/019.
REQ-026 Without HW_QSYS_CPU_2_CPU_DIV_SIGNED_EN, E_div_signed is ignored, every op is unsigned, the sign logic is absent, and the 34-cycle latency is unchanged.

Structure
REQ-027 Package hw_qsys_cpu_2_cpu_div_pkg SHALL hold the state enum, DIV_W=32, DIV_ITER=32 and DIV_LATENCY=34.
REQ-028 One combinational sub-module, hw_qsys_cpu_2_cpu_div_step, SHALL implement a single restoring iteration (shift, trial subtract, select).

Verification
REQ-029 Unsigned 100/7 -> quot=14, rem=2, by_zero=0, div_out_valid exactly 34 cycles after accept.
REQ-030 Signed -100/7 -> quot=0xFFFFFFF2 (-14), rem=0xFFFFFFFE (-2); signed 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0.
REQ-031 0x12345678/0 (both modes) -> quot=0xFFFFFFFF, rem=0x12345678, by_zero=1.
REQ-032 div_out_ready held 0 for 10 cycles after valid -> outputs stable and div_in_ready=0 throughout; release -> IDLE next cycle, back-to-back op accepted.
REQ-033 div_kill at RUN iteration 5, then reset at iteration 20 of a new op -> IDLE next edge each time, no div_out_valid, next op 9/3 -> quot=3, rem=0.

Source files
------------

// File: rtl/hw_qsys_cpu_2_cpu_div_pkg.sv
// Shared types and constants for the CPU divide cell.
// Signed-operation support is enabled by HW_QSYS_CPU_2_CPU_DIV_SIGNED_EN.
package hw_qsys_cpu_2_cpu_div_pkg;

  localparam int DIV_W       = 32;
  localparam int DIV_ITER    = 32;
  localparam int DIV_LATENCY = 34;
  localparam int CNT_W       = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/hw_qsys_cpu_2_cpu_div_step.sv
// One radix-2 restoring division iteration: shift, trial subtract, select.
module hw_qsys_cpu_2_cpu_div_step
  import hw_qsys_cpu_2_cpu_div_pkg::*;
(
  input  logic [DIV_W-1:0] rem_in,
  input  logic [DIV_W-1:0] quo_in,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] rem_out,
  output logic [DIV_W-1:0] quo_out
);

  logic [DIV_W:0] trial_shift;
  logic [DIV_W:0] trial_diff;
  logic           fit;

  // The shifted partial remainder can reach 2^33-2, so the trial runs one bit wider.
  assign trial_shift = {rem_in, quo_in[DIV_W-1]};
  assign trial_diff  = trial_shift - {1'b0, divisor};
  assign fit         = ~trial_diff[DIV_W];

  assign rem_out = fit ? trial_diff[DIV_W-1:0] : trial_shift[DIV_W-1:0];
  assign quo_out = {quo_in[DIV_W-2:0], fit};

endmodule

// File: rtl/hw_qsys_cpu_2_cpu_div_cell.sv
// Iterative 32-bit divider: IDLE -> RUN (32 steps) -> FIX (signs) -> DONE.
// Define HW_QSYS_CPU_2_CPU_DIV_SIGNED_EN to honour E_div_signed; otherwise all ops are unsigned.
module hw_qsys_cpu_2_cpu_div_cell
  import hw_qsys_cpu_2_cpu_div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic              E_div_signed,
  input  logic              div_in_valid,
  output logic              div_in_ready,
  input  logic              div_kill,
  output logic [DATA_W-1:0] M_div_quot,
  output logic [DATA_W-1:0] M_div_rem,
  output logic              M_div_by_zero,
  output logic              div_out_valid,
  input  logic              div_out_ready
);

  div_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              accept;

  logic [DATA_W-1:0] src1_r;
  logic [DATA_W-1:0] dvs_r;
  logic [DATA_W-1:0] rem_r, quo_r;
  logic              by_zero_r;
  logic [DATA_W-1:0] rem_step, quo_step;
  logic [DATA_W-1:0] abs_src1, abs_src2;
  logic [DATA_W-1:0] quo_sgn, rem_sgn;
  logic [DATA_W-1:0] quo_fix, rem_fix;

  assign div_in_ready = (state == ST_IDLE);
  assign accept       = div_in_valid & div_in_ready & ~div_kill;

`ifdef HW_QSYS_CPU_2_CPU_DIV_SIGNED_EN
  logic signed [DATA_W-1:0] src1_s, src2_s;
  logic                     sgn1, sgn2;
  logic                     neg_quo_r, neg_rem_r;

  function automatic logic [DATA_W-1:0] neg_f(input logic [DATA_W-1:0] v);
    return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [DATA_W-1:0] abs_f(input logic signed [DATA_W-1:0] v,
                                              input logic               is_signed);
    return (is_signed && v < 0) ? neg_f(v) : v;
  endfunction

  assign src1_s   = E_src1;
  assign src2_s   = E_src2;
  assign sgn1     = E_div_signed & src1_s[DATA_W-1];
  assign sgn2     = E_div_signed & src2_s[DATA_W-1];
  assign abs_src1 = abs_f(src1_s, E_div_signed);
  assign abs_src2 = abs_f(src2_s, E_div_signed);

  always_ff @(posedge clk) begin
    if (accept) begin
      neg_quo_r <= sgn1 ^ sgn2;
      neg_rem_r <= sgn1;
    end
  end

  assign quo_sgn = neg_quo_r ? neg_f(quo_r) : quo_r;
  assign rem_sgn = neg_rem_r ? neg_f(rem_r) : rem_r;
`else
  logic unused_div_signed;
  assign unused_div_signed = E_div_signed;
  assign abs_src1 = E_src1;
  assign abs_src2 = E_src2;
  assign quo_sgn  = quo_r;
  assign rem_sgn  = rem_r;
`endif

  // Divide-by-zero returns all-ones and the untouched dividend in either mode.
  assign quo_fix = by_zero_r ? {DATA_W{1'b1}} : quo_sgn;
  assign rem_fix = by_zero_r ? src1_r : rem_sgn;

  hw_qsys_cpu_2_cpu_div_step u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .divisor (dvs_r),
    .rem_out (rem_step),
    .quo_out (quo_step)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_RUN;
      ST_RUN:  if (cnt == '0) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: if (div_out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (div_kill && state != ST_IDLE) state_nxt = ST_IDLE;
  end

  // Control and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      div_out_valid <= 1'b0;
      M_div_by_zero <= 1'b0;
      M_div_quot    <= '0;
      M_div_rem     <= '0;
    end else begin
      state         <= state_nxt;
      div_out_valid <= (state_nxt == ST_DONE);
      M_div_by_zero <= (state_nxt == ST_DONE) && by_zero_r;
      if (accept)
        cnt <= CNT_W'(DIV_ITER - 1);
      else if (state == ST_RUN && cnt != '0)
        cnt <= cnt - CNT_W'(1);
      if (state == ST_FIX && state_nxt == ST_DONE) begin
        M_div_quot <= quo_fix;
        M_div_rem  <= rem_fix;
      end
    end
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk) begin
    if (accept) begin
      src1_r    <= E_src1;
      dvs_r     <= abs_src2;
      quo_r     <= abs_src1;
      rem_r     <= '0;
      by_zero_r <= (E_src2 == '0);
    end else if (state == ST_RUN) begin
      rem_r <= rem_step;
      quo_r <= quo_step;
    end
  end

endmodule

// File: tb/tb_hw_qsys_cpu_2_cpu_div_cell.sv
// Directed and randomized checks of hw_qsys_cpu_2_cpu_div_cell against an arithmetic reference.
module tb_hw_qsys_cpu_2_cpu_div_cell;

`ifdef HW_QSYS_CPU_2_CPU_DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  localparam int LAT = 34;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] E_src1, E_src2;
  logic        E_div_signed, div_in_valid, div_in_ready, div_kill;
  logic [31:0] M_div_quot, M_div_rem;
  logic        M_div_by_zero, div_out_valid, div_out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hw_qsys_cpu_2_cpu_div_cell #(.DATA_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .E_src1        (E_src1),
    .E_src2        (E_src2),
    .E_div_signed  (E_div_signed),
    .div_in_valid  (div_in_valid),
    .div_in_ready  (div_in_ready),
    .div_kill      (div_kill),
    .M_div_quot    (M_div_quot),
    .M_div_rem     (M_div_rem),
    .M_div_by_zero (M_div_by_zero),
    .div_out_valid (div_out_valid),
    .div_out_ready (div_out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit sg,
                                  output logic [31:0] q, output logic [31:0] r, output bit bz);
    int sa, sb;
    bz = (b == 0);
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sg && SIGNED_EN) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'h0;
      end else begin
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue one op at a negedge, measure latency, check results, hold, then release.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input bit sg, input int hold);
    logic [31:0] eq, er;
    bit          ebz;
    int          lat;
    ref_div(a, b, sg, eq, er, ebz);
    chk({tag, ".in_ready"}, {31'b0, div_in_ready}, 32'd1);
    E_src1 = a; E_src2 = b; E_div_signed = sg; div_in_valid = 1'b1;
    @(negedge clk);
    div_in_valid = 1'b0;
    lat = 1;
    while (!div_out_valid && lat < LAT + 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, lat, LAT);
    chk({tag, ".quot"}, M_div_quot, eq);
    chk({tag, ".rem"}, M_div_rem, er);
    chk({tag, ".by_zero"}, {31'b0, M_div_by_zero}, {31'b0, ebz});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk($sformatf("%s.hold%0d.valid", tag, i), {31'b0, div_out_valid}, 32'd1);
      chk($sformatf("%s.hold%0d.quot", tag, i), M_div_quot, eq);
      chk($sformatf("%s.hold%0d.rem", tag, i), M_div_rem, er);
      chk($sformatf("%s.hold%0d.in_ready", tag, i), {31'b0, div_in_ready}, 32'd0);
    end
    div_out_ready = 1'b1;
    @(negedge clk);
    div_out_ready = 1'b0;
    chk({tag, ".rel.valid"}, {31'b0, div_out_valid}, 32'd0);
    chk({tag, ".rel.by_zero"}, {31'b0, M_div_by_zero}, 32'd0);
    chk({tag, ".rel.in_ready"}, {31'b0, div_in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          rs;
    int          seen;
    reset = 1'b1; E_src1 = '0; E_src2 = '0; E_div_signed = 1'b0;
    div_in_valid = 1'b0; div_kill = 1'b0; div_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst.in_ready", {31'b0, div_in_ready}, 32'd1);
    chk("rst.valid", {31'b0, div_out_valid}, 32'd0);
    chk("rst.quot", M_div_quot, 32'd0);
    chk("rst.rem", M_div_rem, 32'd0);
    chk("rst.by_zero", {31'b0, M_div_by_zero}, 32'd0);

    do_op("u100_7", 32'd100, 32'd7, 1'b0, 0);
    do_op("s-100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 0);
    do_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    do_op("u_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    do_op("u_div0", 32'h1234_5678, 32'd0, 1'b0, 0);
    do_op("s_div0", 32'h1234_5678, 32'd0, 1'b1, 0);
    do_op("s_neg_div0", 32'hF234_5678, 32'd0, 1'b1, 0);
    do_op("hold10", 32'd1000, 32'd33, 1'b0, 10);
    do_op("b2b", 32'hDEAD_BEEF, 32'd12345, 1'b0, 0);

    // Kill while idle must block acceptance.
    E_src1 = 32'd50; E_src2 = 32'd5; div_in_valid = 1'b1; div_kill = 1'b1;
    @(negedge clk);
    div_in_valid = 1'b0; div_kill = 1'b0;
    chk("kill_idle.in_ready", {31'b0, div_in_ready}, 32'd1);
    seen = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (div_out_valid) seen++;
    end
    chk("kill_idle.no_valid", seen, 0);

    // Kill at RUN iteration 5.
    E_src1 = 32'd77; E_src2 = 32'd3; div_in_valid = 1'b1;
    @(negedge clk);
    div_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    div_kill = 1'b1;
    @(negedge clk);
    div_kill = 1'b0;
    chk("kill_run.in_ready", {31'b0, div_in_ready}, 32'd1);
    chk("kill_run.valid", {31'b0, div_out_valid}, 32'd0);

    // Reset at iteration 20 of a new op.
    E_src1 = 32'd999; E_src2 = 32'd4; div_in_valid = 1'b1;
    @(negedge clk);
    div_in_valid = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_run.in_ready", {31'b0, div_in_ready}, 32'd1);
    chk("rst_run.valid", {31'b0, div_out_valid}, 32'd0);
    chk("rst_run.quot", M_div_quot, 32'd0);
    seen = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (div_out_valid) seen++;
    end
    chk("kill_rst.no_valid", seen, 0);
    do_op("after_kill_9_3", 32'd9, 32'd3, 1'b0, 0);

    // Kill while the result is waiting.
    E_src1 = 32'd64; E_src2 = 32'd8; div_in_valid = 1'b1;
    @(negedge clk);
    div_in_valid = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    chk("kill_done.pre_valid", {31'b0, div_out_valid}, 32'd1);
    div_kill = 1'b1;
    @(negedge clk);
    div_kill = 1'b0;
    chk("kill_done.valid", {31'b0, div_out_valid}, 32'd0);
    chk("kill_done.in_ready", {31'b0, div_in_ready}, 32'd1);

    for (int k = 0; k < 24; k++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 255);
        2: rb = -$urandom_range(1, 255);
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      do_op($sformatf("rnd%0d", k), ra, rb, rs, k % 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
